// File: rtl/mem_st_buf_pkg.sv
// Shared memory-op encoding and store-buffer entry layout for the Mem stages.
package mem_st_buf_pkg;

  localparam int MEM_ST  = 4;
  localparam int MEM_W   = 3;
  localparam int MEM_H   = 2;
  localparam int MEM_B   = 1;
  localparam int MEM_SGN = 0;

  localparam int ST_AW = 32;
  localparam int ST_DW = 32;

  typedef struct packed {
    logic [ST_AW-3:0] addr;
    logic [ST_DW-1:0] data;
    logic [3:0]       strb;
  } StBufEntry;

  function automatic logic isOneHot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/mem_st_buf_st_align.sv
// Combinational store aligner: replicates store data into word lanes and
// derives byte strobes plus a misalignment flag for legal store ops.
module st_align
  import mem_st_buf_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] data,
  output logic [31:0] alData,
  output logic [3:0]  alStrb,
  output logic        legal,
  output logic        misalign
);

  logic unusedSgn_s;
  logic rawMisalign_s;

  assign unusedSgn_s = op[MEM_SGN];
  assign legal       = op[MEM_ST] & isOneHot3(op[MEM_W:MEM_B]);
  assign misalign    = legal & rawMisalign_s;

  // Lane replication and strobe generation by access size
  always_comb begin
    alData        = data;
    alStrb        = 4'b0000;
    rawMisalign_s = 1'b0;
    if (op[MEM_B]) begin
      alData = {4{data[7:0]}};
      alStrb = 4'b0001 << addrLo;
    end else if (op[MEM_H]) begin
      alData        = {2{data[15:0]}};
      alStrb        = addrLo[1] ? 4'b1100 : 4'b0011;
      rawMisalign_s = addrLo[0];
    end else if (op[MEM_W]) begin
      alData        = data;
      alStrb        = 4'b1111;
      rawMisalign_s = (addrLo != 2'b00);
    end else begin
      alStrb        = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_st_buf.sv
// In-order store buffer between Mem1 and the dcache write port, with
// word-granular load hazard detection against pending entries.
module mem_st_buf
  import mem_st_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_st_valid,
  output logic                     o_st_ready,
  input  logic [4:0]               i_st_op,
  input  logic [AW-1:0]            i_st_addr,
  input  logic [DW-1:0]            i_st_data,
  output logic                     o_misalign,
  output logic                     o_dc_valid,
  input  logic                     i_dc_ready,
  output logic [AW-1:0]            o_dc_addr,
  output logic [DW-1:0]            o_dc_data,
  output logic [3:0]               o_dc_strb,
  input  logic                     i_ld_valid,
  input  logic [AW-1:0]            i_ld_addr,
  output logic                     o_ld_hazard,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] alData_s;
  logic [3:0]    alStrb_s;
  logic          legal_s;
  logic          misal_s;
  logic          accept_s;
  logic          enq_s;
  logic          deq_s;
  logic          full_s;
  logic          hazard_s;
  logic [1:0]    unusedLdLo_s;

  logic [PW-1:0]    wrPtr_r;
  logic [PW-1:0]    rdPtr_r;
  logic [CW-1:0]    count_r;
  logic             misalign_r;
  logic [DEPTH-1:0] valid_r;
  StBufEntry        mem_r [DEPTH];

  st_align uAlign (
    .op       (i_st_op),
    .addrLo   (i_st_addr[1:0]),
    .data     (i_st_data),
    .alData   (alData_s),
    .alStrb   (alStrb_s),
    .legal    (legal_s),
    .misalign (misal_s)
  );

  // Ready depends only on registered occupancy, never on i_dc_ready
  assign full_s   = (count_r == CW'(DEPTH));
  assign accept_s = i_st_valid & ~full_s & legal_s;
  assign enq_s    = accept_s & ~misal_s;
  assign deq_s    = valid_r[rdPtr_r] & i_dc_ready;

  assign unusedLdLo_s = i_ld_addr[1:0];

  // FIFO storage, pointers, occupancy and misalign pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      count_r    <= '0;
      misalign_r <= 1'b0;
      valid_r    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      misalign_r <= accept_s & misal_s;
      if (deq_s) begin
        valid_r[rdPtr_r] <= 1'b0;
        rdPtr_r          <= rdPtr_r + PW'(1);
      end
      if (enq_s) begin
        mem_r[wrPtr_r].addr <= i_st_addr[AW-1:2];
        mem_r[wrPtr_r].data <= alData_s;
        mem_r[wrPtr_r].strb <= alStrb_s;
        valid_r[wrPtr_r]    <= 1'b1;
        wrPtr_r             <= wrPtr_r + PW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Word-address match of the load probe against every pending entry
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && (mem_r[i].addr == i_ld_addr[AW-1:2])) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  assign o_ld_hazard = i_ld_valid & hazard_s;
  assign o_st_ready  = ~full_s;
  assign o_misalign  = misalign_r;
  assign o_dc_valid  = valid_r[rdPtr_r];
  assign o_dc_addr   = {mem_r[rdPtr_r].addr, 2'b00};
  assign o_dc_data   = mem_r[rdPtr_r].data;
  assign o_dc_strb   = mem_r[rdPtr_r].strb;
  assign o_count     = count_r;
  assign o_empty     = (count_r == CW'(0));

endmodule

// File: doc/mem_st_buf.md
Name: mem_st_buf

Overview:
- Store-side counterpart of the Mem2 load-data extraction path.
- Accepts store ops (sb/sh/sw) from the Mem1 stage and aligns the store data into 32-bit word lanes with byte strobes.
- Queues the aligned stores in a small in-order FIFO and drains them to the dcache write port with a valid/ready handshake.
- Flags loads that hit a word still pending in the buffer, so the pipeline can stall them.

Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2.
- AW, 32, address width.
- DW, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- i_st_valid  input  1  store request valid
- o_st_ready  output  1  buffer can accept (= !full)
- i_st_op  input  5  MemOpEn encoding: [4]=store, [3]=word, [2]=half, [1]=byte, [0]=signed (ignored for stores)
- i_st_addr  input  AW  byte address
- i_st_data  input  DW  unaligned store data, LSB-justified
- o_misalign  output  1  one-cycle pulse, store rejected as misaligned
- o_dc_valid  output  1  head entry valid toward dcache
- i_dc_ready  input  1  dcache accepts head
- o_dc_addr  output  AW  word address, [1:0] forced to 0
- o_dc_data  output  DW  lane-aligned data
- o_dc_strb  output  4  byte write strobes
- i_ld_valid  input  1  load probe valid
- i_ld_addr  input  AW  load byte address
- o_ld_hazard  output  1  load word matches a pending store
- o_count  output  $clog2(DEPTH)+1  occupancy
- o_empty  output  1  no pending stores

Behaviour:
- Reset (async, rst_n=0): wr/rd pointers=0, count=0, o_misalign=0, all entry valid bits=0.
  - Consequently o_dc_valid=0, o_ld_hazard=0, o_st_ready=1, o_empty=1.
- Legal op: i_st_op[4]=1 and exactly one of [3:1] set. Otherwise the op is not a store; it is ignored, with no enqueue and no misalign.
- Alignment (combinational, sub-module):
  - byte: data = {4{d[7:0]}}, strb = 4'b0001 << addr[1:0].
  - half: data = {2{d[15:0]}}, strb = 4'b0011 << (2*addr[1]).
  - word: data = d, strb = 4'b1111.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - Such a store is not enqueued.
  - o_misalign is registered: it is high exactly the cycle after the accepting handshake (valid & ready & legal), for one cycle.
  - o_st_ready is unaffected.
- Enqueue: valid & ready & legal & aligned. The entry {word addr, data, strb} is written at wr_ptr and wr_ptr increments, wrapping mod DEPTH.
- Dequeue: o_dc_valid & i_dc_ready; rd_ptr increments, wrapping.
  - o_dc_* reflect the head entry directly from storage, with zero added latency.
  - The head holds stable while o_dc_valid=1 and i_dc_ready=0.
- Count: +1 on enqueue only, −1 on dequeue only, unchanged on both or neither.
- Full (count=DEPTH): o_st_ready=0 even if a dequeue occurs the same cycle. There is no combinational ready-from-ready path.
- Empty plus a same-cycle enqueue: o_dc_valid rises the next cycle, so minimum store-to-dcache latency is 1 cycle.
- Hazard: o_ld_hazard = i_ld_valid & OR over valid entries of (entry.addr[AW-1:2] == i_ld_addr[AW-1:2]).
  - Combinational, word-granular, no strobe check.
  - The entry being dequeued this cycle still counts.
  - A store being enqueued this cycle does not count.
- Stores leave strictly in FIFO order. No merging, no forwarding data.

Decomposition:
- ZionDataType package additions:
  - MemOp bit-index constants (MEM_ST=4, MEM_W=3, MEM_H=2, MEM_B=1, MEM_SGN=0).
  - StBufEntry struct {addr word, data, strb}.
- One sub-module: st_align. It is combinational and takes op, addr[1:0] and data, producing aligned data, strb and misalign. It is reused later by the uncached store path.

Test Plan:
1. Alignment:
   - sb addr=0x1003 data=0xAB → dc_addr=0x1000, data=0xABABABAB, strb=1000.
   - sh addr=0x1002 data=0x1234 → data=0x12341234, strb=1100.
   - sw addr=0x2000 → strb=1111.
2. Misalign: sh addr=0x1001 → next cycle o_misalign=1 for one cycle, count stays 0. sw addr=0x2002 → same.
3. Full/backpressure: i_dc_ready=0, push 4 stores → count=4, o_st_ready=0, 5th request held. Then i_dc_ready=1 → 4 dequeues in order; ready returns the cycle after the first dequeue.
4. Simultaneous: count=2, enqueue and dequeue in the same cycle → count stays 2; data order preserved across pointer wrap (10 stores total).
5. Hazard:
   - Pending sw 0x3000, load probe 0x3002 → hazard=1.
   - Probe 0x3004 → 0.
   - After the entry dequeues → 0.
   - Probe in the same cycle as the 0x3000 enqueue → 0.
6. Reset mid-operation: 3 entries pending, assert rst_n=0 asynchronously → o_dc_valid=0, count=0, hazard=0 immediately; after release, the first new store appears at the head.
